tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Top-level sequencer for the brightness-filter systolic datapath. It walks an image stored in RAM as consecutive 4x4 tiles of 16 words each. For every tile it triggers the matrix loader, feeds the 2N-1 skewed diagonals into the systolic array one per cycle, and writes the array's 16 results back to an output region of the same RAM. It also owns the single RAM address/write port, time-sharing it between loader reads and result write-back.

## Interface
- ADDR_WIDTH, 6, RAM word-address width
- DATA_WIDTH, 16, pixel/result word width
- N, 4, tile edge; tile = N*N words
- NUM_TILES, 2, tiles processed per run; input tile t at t*N*N
- OUT_BASE, 32, word address of output tile 0
- TIMEOUT, 64, max cycles between result beats in DRAIN
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  begin run; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- error  out  1  sticky timeout flag; cleared by next accepted start
- ld_start  out  1  one-cycle loader trigger
- ld_done  in  1  loader finished current tile
- ld_addr  in  ADDR_WIDTH  loader tile-local read address (0..N*N-1)
- sa_clear  out  1  clear array accumulators
- sa_valid  out  1  diagonal index valid this cycle
- sa_diag  out  3  diagonal index 0..2N-2
- res_valid  in  1  array result beat
- res_data  in  DATA_WIDTH  result, raster order within tile
- ram_addr  out  ADDR_WIDTH  shared RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data

## Operation
- States: IDLE, LOAD, FEED, DRAIN, NEXT, FIN.
- IDLE: start=1 → tile=0, error=0 → LOAD.
- LOAD: ld_start and sa_clear high on first LOAD cycle only. ram_addr = tile*N*N + ld_addr, combinational, ram_we=0. ld_done=1 → FEED.
- FEED: exactly 2N-1 cycles, sa_valid=1, sa_diag = 0,1,…,2N-2. After the last diagonal → DRAIN.
- DRAIN: each res_valid beat writes: ram_we=1, ram_addr = OUT_BASE + tile*N*N + res_cnt, ram_wdata = res_data; res_cnt++. After the N*N-th beat → NEXT. A timeout counter resets on each beat. Reaching TIMEOUT sets error and goes to FIN; no further writes.
- NEXT: one cycle. If tile==NUM_TILES-1 → FIN, else tile++ → LOAD.
- FIN: done=1 for one cycle → IDLE.
- Ignored inputs: start when not IDLE; ld_done outside LOAD; res_valid outside DRAIN.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps, no flag).
- Reset mid-run: next cycle is IDLE, no write, counters cleared. error is cleared. RAM contents already written stay as they are.

## Timing
- Reset values: busy=0, done=0, error=0, ld_start=0, sa_clear=0, sa_valid=0, sa_diag=0, ram_we=0, ram_wdata=0, ram_addr=0.
- All outputs are registered, except ram_addr in LOAD, which is a combinational path from ld_addr so the loader sees RAM data in the same cycle.
- start sampled at edge 0 → LOAD at cycle 1, ld_start high in cycle 1.
- ld_done seen in cycle k → FEED in cycles k+1..k+2N-1 → DRAIN from k+2N.
- A write occurs in the cycle after its res_valid beat (registered). The 16th write precedes NEXT by 0 cycles: NEXT is the cycle of the last write.
- done is asserted 1 cycle after NEXT of the final tile, or 1 cycle after the timeout is detected. busy falls in the cycle after done.
- Minimum per-tile overhead, excluding loader and array latency: 1 (LOAD entry) + 7 (FEED) + 1 (NEXT) cycles.

## Structure
- Shared package systolic_pkg:
  - sched_state_t enum
  - N, TILE_WORDS = N*N, DIAGS = 2N-1
  - diagonal index width
- Sub-module tile_addr_gen: computes the read address (tile*TILE_WORDS + ld_addr) and the write address (OUT_BASE + tile*TILE_WORDS + res_cnt), and muxes them by state onto ram_addr.

## Test plan
- Reset check: rst=0 for 2 cycles during DRAIN → next cycle all outputs 0, state IDLE, no ram_we pulse afterwards.
- Single tile, NUM_TILES=1: loader model asserts ld_done 17 cycles after ld_start; array model returns res_data = 0x0100+i → RAM[32..47] = 0x0100..0x010F, sa_diag sequence 0..6, one done pulse, error=0.
- Two tiles: input RAM[0..31] loaded, results written to RAM[32..63]. ram_addr during the tile-1 LOAD = 16 + ld_addr. done occurs exactly once, after the 32nd write.
- Timeout: array returns 5 beats, then silence → error=1 after TIMEOUT=64 idle cycles, done pulse, RAM[37..47] untouched. The next start clears error.
- Protocol noise:
  - start held high throughout a run → no restart.
  - res_valid pulses during FEED and ld_done during DRAIN → no writes, no state change.
- Back-to-back: start asserted the cycle after done → a new run starts from IDLE. Beats separated by 3 idle cycles still complete the run without error.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the brightness-filter systolic datapath.
// Scheduler states plus tile geometry used by the sequencer.
package systolic_pkg;

  localparam int N = 4;
  localparam int TILE_WORDS = N * N;
  localparam int DIAGS = 2 * N - 1;
  localparam int DIAG_W = $clog2(DIAGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_NEXT,
    S_FIN
  } sched_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Shared RAM address generation: loader read address vs result write address.
// The read path stays combinational so the loader sees data in the same cycle.
module tile_addr_gen
  import systolic_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int WORDS = 16,
  parameter int CNT_W = 4,
  parameter int TILE_W = 1,
  parameter int OUT_BASE = 32
) (
  input  sched_state_t          state,
  input  logic [TILE_W-1:0]     tile,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [CNT_W-1:0]      res_cnt,
  input  logic [ADDR_WIDTH-1:0] wr_hold,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_addr
);

  logic [ADDR_WIDTH-1:0] base;

  assign base = ADDR_WIDTH'(tile) * ADDR_WIDTH'(WORDS);

  assign wr_addr = ADDR_WIDTH'(OUT_BASE) + base
                 + ADDR_WIDTH'(res_cnt);

  // wr_hold is the registered address of the write in flight
  assign ram_addr = (state == S_LOAD) ? base + ld_addr : wr_hold;

endmodule

// File: rtl/tile_scheduler.sv
// Tile-by-tile sequencer for the brightness-filter systolic datapath.
// Triggers the loader, feeds diagonals, writes results back to RAM.
module tile_scheduler #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int N = 4,
  parameter int NUM_TILES = 2,
  parameter int OUT_BASE = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  ld_start,
  input  logic                  ld_done,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  sa_clear,
  output logic                  sa_valid,
  output logic [2:0]            sa_diag,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata
);

  import systolic_pkg::*;

  localparam int WORDS = N * N;
  localparam int CNT_W = $clog2(WORDS);
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] LAST_DIAG = 3'(2 * N - 2);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  sched_state_t state_q, state_d;

  logic [TILE_W-1:0]     tile_q, tile_d;
  logic [CNT_W-1:0]      res_cnt_q, res_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [2:0]            diag_d;
  logic busy_d, done_d, error_d;
  logic ld_start_d, clear_d, valid_d, we_d;

  tile_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORDS(WORDS),
    .CNT_W(CNT_W),
    .TILE_W(TILE_W),
    .OUT_BASE(OUT_BASE)
  ) u_addr (
    .state(state_q),
    .tile(tile_q),
    .ld_addr(ld_addr),
    .res_cnt(res_cnt_q),
    .wr_hold(wr_addr_q),
    .wr_addr(wr_addr),
    .ram_addr(ram_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tile_q    <= '0;
      res_cnt_q <= '0;
      to_cnt_q  <= '0;
      wr_addr_q <= '0;
      ram_wdata <= '0;
      sa_diag   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ld_start  <= 1'b0;
      sa_clear  <= 1'b0;
      sa_valid  <= 1'b0;
      ram_we    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      res_cnt_q <= res_cnt_d;
      to_cnt_q  <= to_cnt_d;
      wr_addr_q <= wr_addr_d;
      ram_wdata <= wdata_d;
      sa_diag   <= diag_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      ld_start  <= ld_start_d;
      sa_clear  <= clear_d;
      sa_valid  <= valid_d;
      ram_we    <= we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    res_cnt_d  = res_cnt_q;
    to_cnt_d   = to_cnt_q;
    wr_addr_d  = wr_addr_q;
    wdata_d    = ram_wdata;
    diag_d     = '0;
    error_d    = error;
    done_d     = 1'b0;
    ld_start_d = 1'b0;
    clear_d    = 1'b0;
    valid_d    = 1'b0;
    we_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          tile_d     = '0;
          error_d    = 1'b0;
          ld_start_d = 1'b1;
          clear_d    = 1'b1;
        end
      end
      S_LOAD: begin
        if (ld_done) begin
          state_d = S_FEED;
          valid_d = 1'b1;
        end
      end
      S_FEED: begin
        if (sa_diag == LAST_DIAG) begin
          state_d   = S_DRAIN;
          res_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          valid_d = 1'b1;
          diag_d  = sa_diag + 3'd1;
        end
      end
      S_DRAIN: begin
        // a beat always wins over a simultaneous timeout
        if (res_valid) begin
          we_d      = 1'b1;
          wdata_d   = res_data;
          wr_addr_d = wr_addr;
          res_cnt_d = res_cnt_q + 1'b1;
          to_cnt_d  = '0;
          if (res_cnt_q == LAST_WORD) state_d = S_NEXT;
        end else if (to_cnt_q == TO_LAST) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (tile_q == LAST_TILE) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          tile_d     = tile_q + 1'b1;
          state_d    = S_LOAD;
          ld_start_d = 1'b1;
          clear_d    = 1'b1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: loader/array models, write scoreboard, RAM image.
// Table of run scenarios, random runs and hand-written reset sequences.
module tb_tile_scheduler;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int NT = 2;
  localparam int OB = 32;
  localparam int TO = 64;
  localparam int NDIAG = 7;

  logic clk, rst, start, ld_done, res_valid;
  logic [AW-1:0] ld_addr, ram_addr;
  logic [DW-1:0] res_data, ram_wdata;
  logic busy, done, error, ld_start, sa_clear, sa_valid, ram_we;
  logic [2:0] sa_diag;

  tile_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N(4),
    .NUM_TILES(NT), .OUT_BASE(OB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .error(error),
    .ld_start(ld_start), .ld_done(ld_done), .ld_addr(ld_addr),
    .sa_clear(sa_clear), .sa_valid(sa_valid), .sa_diag(sa_diag),
    .res_valid(res_valid), .res_data(res_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ld_lat;
    int arr_lat;
    int gap;
    int nbeats;
    bit noise;
    bit hold;
    bit ramp;
    bit b2b;
    bit exp_err;
    int exp_writes;
  } vec_t;

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  int nvec = 0;
  int nerr = 0;
  bit prev_err = 0;
  wr_t sb[$];
  logic [DW-1:0] mem [64];
  logic [DW-1:0] exp_mem [64];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_ld_start"}, ld_start, 0);
    chk({tag, "_sa_clear"}, sa_clear, 0);
    chk({tag, "_sa_valid"}, sa_valid, 0);
    chk({tag, "_sa_diag"}, sa_diag, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 0; ld_done = 0; res_valid = 0;
    repeat (n) step();
  endtask

  task automatic prep_mem();
    for (int a = 0; a < 64; a++) begin
      if (a < OB) mem[a] = 16'($urandom);
      else mem[a] = 16'hBEEF;
      exp_mem[a] = mem[a];
    end
  endtask

  // One full run: loader and array react to the DUT, writes go to the scoreboard
  task automatic run(input vec_t v);
    int c, ldc, ld_done_c, last_w, last_b, done_c;
    int tile_m, loads, diag, beat, nxt, dones, writes;
    bit ld_act, arr_act, in_load;
    logic [DW-1:0] d;
    wr_t w;
    c = 0; ldc = 0; ld_done_c = -1; last_w = -1; last_b = -1;
    done_c = -1; tile_m = 0; loads = 0; diag = 0; beat = 0;
    nxt = 0; dones = 0; writes = 0; ld_act = 0; arr_act = 0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_error", error, prev_err);
    start = 1; ld_done = 0; res_valid = 0;
    while (done_c < 0 && c < 3000) begin
      step();
      c++;
      if (ram_we) begin
        writes++;
        if (sb.size() == 0) chk("extra_write", 1, 0);
        else begin
          w = sb.pop_front();
          chk("wr_addr", ram_addr, w.a);
          chk("wr_data", ram_wdata, w.d);
          chk("wr_cycle", c, w.c);
        end
        mem[ram_addr] = ram_wdata;
        last_w = c;
      end
      if (c == 1) chk("err_cleared", error, 0);
      chk("busy", busy, 1);
      if (ld_start) begin
        chk("sa_clear", sa_clear, 1);
        chk("ld_start_cyc", c, (loads == 0) ? 1 : last_w + 1);
        tile_m = loads;
        loads++;
        ld_act = 1;
        ldc = v.ld_lat;
      end
      if (sa_valid) begin
        chk("sa_diag", sa_diag, diag);
        if (diag == 0) chk("feed_cyc", c, ld_done_c + 1);
        diag++;
        if (diag == NDIAG) begin
          diag = 0; arr_act = 1; beat = 0; nxt = c + 1 + v.arr_lat;
        end
      end
      if (done) begin
        done_c = c;
        dones++;
        chk("done_error", error, v.exp_err);
        chk("done_cyc", c, v.exp_err ? last_b + TO + 1 : last_w + 1);
      end
      start = v.hold && done_c < 0;
      ld_done = 0;
      res_valid = 0;
      res_data = 16'($urandom);
      ld_addr = AW'($urandom_range(0, 15));
      in_load = ld_act;
      if (ld_act) begin
        if (ldc == 0) begin
          ld_done = 1; ld_act = 0; ld_done_c = c;
        end else ldc--;
      end
      if (sa_valid && v.noise) begin
        res_valid = 1; res_data = 16'hDEAD;
      end
      if (arr_act && c == nxt && beat < v.nbeats) begin
        d = v.ramp ? 16'(16'h0100 + tile_m * 16 + beat) : 16'($urandom);
        res_valid = 1;
        res_data = d;
        sb.push_back('{a: (OB + tile_m * 16 + beat) % 64, d: int'(d),
                       c: c + 1});
        exp_mem[(OB + tile_m * 16 + beat) % 64] = d;
        beat++;
        nxt = c + 1 + v.gap;
        last_b = c;
        if (beat == 16) arr_act = 0;
      end else if (arr_act && v.noise) ld_done = 1;
      if (arr_act && beat >= v.nbeats) arr_act = 0;
      #1;
      if (in_load)
        chk("rd_addr", ram_addr, (tile_m * 16 + int'(ld_addr)) % 64);
    end
    if (done_c < 0) chk("run_budget", 0, 1);
    start = 0; ld_done = 0; res_valid = 0;
    chk("dones", dones, 1);
    chk("writes", writes, v.exp_writes);
    chk("loads", loads, v.exp_err ? 1 : NT);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
    for (int a = OB; a < 64; a++) chk("mem", mem[a], exp_mem[a]);
    prev_err = v.exp_err;
  endtask

  vec_t tbl[5];
  vec_t rv;
  int n;

  initial begin
    rst = 0; start = 0; ld_done = 0; res_valid = 0;
    ld_addr = '0; res_data = '0;
    repeat (3) step();
    chk_zero("reset");
    rst = 1;
    idle(2);

    tbl[0] = '{17, 2, 0, 16, 0, 0, 1, 0, 0, 32};
    tbl[1] = '{0, 0, 3, 16, 0, 0, 0, 1, 0, 32};
    tbl[2] = '{4, 1, 1, 16, 1, 1, 0, 0, 0, 32};
    tbl[3] = '{3, 2, 0, 5, 0, 0, 0, 0, 1, 5};
    tbl[4] = '{1, 0, 0, 16, 0, 0, 1, 0, 0, 32};

    for (int i = 0; i < 5; i++) begin
      prep_mem();
      run(tbl[i]);
      if (i == 0) begin
        chk("ramp_first", mem[32], 16'h0100);
        chk("ramp_last_t0", mem[47], 16'h010F);
        chk("ramp_last_t1", mem[63], 16'h011F);
      end
      if (i == 3) begin
        chk("to_written", mem[36], exp_mem[36]);
        chk("to_untouched", mem[37], 16'hBEEF);
      end
      if (!tbl[i].b2b) idle(3);
    end

    for (int i = 0; i < 6; i++) begin
      rv = '{$urandom_range(0, 20), $urandom_range(0, 4),
             $urandom_range(0, 3), 16, 1'($urandom), 1'($urandom),
             0, 0, 0, 32};
      prep_mem();
      run(rv);
      idle(int'($urandom_range(0, 2)));
    end

    // reset asserted for two cycles in the middle of DRAIN
    step();
    start = 1;
    n = 0;
    do begin step(); start = 0; n++; end while (!ld_start && n < 50);
    chk("rs_ld_start", ld_start, 1);
    ld_done = 1;
    step();
    ld_done = 0;
    n = 0;
    while (sa_valid && n < 20) begin step(); n++; end
    chk("rs_in_drain", busy & ~sa_valid, 1);
    res_valid = 1; res_data = 16'h1234;
    step();
    chk("rs_first_we", ram_we, 1);
    chk("rs_first_addr", ram_addr, OB);
    step();
    step();
    res_valid = 0; rst = 0;
    step();
    chk_zero("midrst");
    res_valid = 1; ld_done = 1;
    step();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      res_valid = 1'($urandom); ld_done = 1'($urandom);
      step();
      chk("post_rst_we", ram_we, 0);
      chk("post_rst_busy", busy, 0);
    end
    res_valid = 0; ld_done = 0;
    prev_err = 0;
    prep_mem();
    run(tbl[1]);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
